// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the registered 1-to-4 demux.
//   SEL_A..SEL_D : select codes for destinations a..d
//   DEMUX_WAYS   : number of output buses
//   sel_onehot() : 2-to-4 one-hot decode used by demux_sel_decode
package demux_pkg;

  localparam int DEMUX_WAYS = 4;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  function automatic logic [DEMUX_WAYS-1:0] sel_onehot(input logic [1:0] sel);
    logic [DEMUX_WAYS-1:0] oh;
    oh = '0;
    case (sel)
      SEL_A:   oh[0] = 1'b1;
      SEL_B:   oh[1] = 1'b1;
      SEL_C:   oh[2] = 1'b1;
      default: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_sel_decode.sv
// demux_sel_decode: combinational 2-to-4 one-hot decoder.
//   sel [1:0] : destination select
//   oh  [3:0] : one-hot, bit i set when sel == i
module demux_sel_decode
  import demux_pkg::*;
(
  input  logic [1:0]            sel,
  output logic [DEMUX_WAYS-1:0] oh
);

  always_comb begin
    oh = sel_onehot(sel);
  end

endmodule

// File: rtl/demux_nbit_x4_reg.sv
// demux_nbit_x4_reg: registered 1-to-4 demultiplexer.
//   clk      : clock, rising edge
//   rst_n    : async active-low reset, clears all outputs
//   en       : update enable; low holds all outputs
//   sel [1:0]: destination select (0->a, 1->b, 2->c, 3->d)
//   y        : data to route (BUS_WIDTH)
//   a,b,c,d  : registered destination buses (BUS_WIDTH)
// Build option DEMUX_HOLD_UNSEL_EN: when defined, unselected outputs keep
// their value on an enabled edge; otherwise they clear to 0.
module demux_nbit_x4_reg
  import demux_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           sel,
  input  logic [BUS_WIDTH-1:0] y,
  output logic [BUS_WIDTH-1:0] a,
  output logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] c,
  output logic [BUS_WIDTH-1:0] d
);

  logic [DEMUX_WAYS-1:0]                sel_oh;
  logic [DEMUX_WAYS-1:0][BUS_WIDTH-1:0] q;

  demux_sel_decode u_dec (
    .sel (sel),
    .oh  (sel_oh)
  );

  // One register per way, all in one process so the packed array has a
  // single driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      for (int w = 0; w < DEMUX_WAYS; w++) begin
        if (sel_oh[w]) begin
          q[w] <= y;
        end else begin
`ifdef DEMUX_HOLD_UNSEL_EN
          q[w] <= q[w];
`else
          q[w] <= '0;
`endif
        end
      end
    end
  end

  assign a = q[0];
  assign b = q[1];
  assign c = q[2];
  assign d = q[3];

endmodule

// File: tb/tb_demux_nbit_x4_reg.sv
// Self-checking bench for demux_nbit_x4_reg (BUS_WIDTH=8 plus a 1-bit instance).
// Honours DEMUX_HOLD_UNSEL_EN so the same bench covers both builds.
module tb_demux_nbit_x4_reg;

`ifdef DEMUX_HOLD_UNSEL_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [7:0] y;
  logic [7:0] a, b, c, d;

  logic       en1;
  logic [1:0] sel1;
  logic [0:0] y1;
  logic [0:0] a1, b1, c1, d1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] model [4];

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [7:0] y;
    logic [7:0] ea, eb, ec, ed;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  demux_nbit_x4_reg #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .y(y),
    .a(a), .b(b), .c(c), .d(d)
  );

  demux_nbit_x4_reg #(.BUS_WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .sel(sel1), .y(y1),
    .a(a1), .b(b1), .c(c1), .d(d1)
  );

  function automatic logic [7:0] pk(input logic [7:0] hold_v, input logic [7:0] clr_v);
    return HOLD ? hold_v : clr_v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [7:0] ea, eb, ec, ed);
    chk({nm, ".a"}, a, ea);
    chk({nm, ".b"}, b, eb);
    chk({nm, ".c"}, c, ec);
    chk({nm, ".d"}, d, ed);
  endtask

  // Reference: one enabled edge writes y to the selected way; the others
  // clear or keep depending on the build.
  task automatic model_edge(input logic e, input logic [1:0] s, input logic [7:0] v);
    if (e) begin
      for (int w = 0; w < 4; w++) begin
        if (w == int'(s)) model[w] = v;
        else if (!HOLD)   model[w] = 8'h00;
      end
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 4; w++) model[w] = 8'h00;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 8'h11, 8'h11,            8'h00,            8'h00,            8'h00};
    tbl[1] = '{1'b1, 2'd1, 8'h22, pk(8'h11, 8'h00), 8'h22,            8'h00,            8'h00};
    tbl[2] = '{1'b1, 2'd2, 8'h33, pk(8'h11, 8'h00), pk(8'h22, 8'h00), 8'h33,            8'h00};
    tbl[3] = '{1'b1, 2'd3, 8'h44, pk(8'h11, 8'h00), pk(8'h22, 8'h00), pk(8'h33, 8'h00), 8'h44};
    tbl[4] = '{1'b1, 2'd1, 8'h5A, pk(8'h11, 8'h00), 8'h5A,            pk(8'h33, 8'h00), pk(8'h44, 8'h00)};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{1'b0, 2'd3, 8'hC3, pk(8'h11, 8'h00), 8'h5A,          pk(8'h33, 8'h00), pk(8'h44, 8'h00)};
    tbl[8] = '{1'b1, 2'd0, 8'hAA, 8'hAA,            pk(8'h5A, 8'h00), pk(8'h33, 8'h00), pk(8'h44, 8'h00)};
    tbl[9] = '{1'b1, 2'd2, 8'hBB, pk(8'hAA, 8'h00), pk(8'h5A, 8'h00), 8'hBB,            pk(8'h44, 8'h00)};

    rst_n = 1'b1; en = 1'b1; sel = 2'd0; y = 8'hFF;
    en1 = 1'b0; sel1 = 2'd0; y1 = 1'b0;

    // Reset asserts between edges: outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1 chk4("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
      chk4("rst_held", 8'h00, 8'h00, 8'h00, 8'h00);
    end
    rst_n = 1'b1;
    model_clear();

    // Sweep, enable hold and hold-build scenarios.
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; sel = tbl[i].sel; y = tbl[i].y;
      @(posedge clk); #1;
      chk4($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed);
    end

    // Mid-stream reset with en still high: clears immediately.
    en = 1'b1; sel = 2'd1; y = 8'h77;
    #2 rst_n = 1'b0;
    #1 chk4("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk4("rst_mid_edge", 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    model_clear();

    // Random routing against the reference model.
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; sel = 2'(i % 4); y = 8'($urandom_range(1, 255));
      @(posedge clk);
      model_edge(en, sel, y);
      #1;
      chk4($sformatf("rnd%0d", i), model[0], model[1], model[2], model[3]);
    end

    // Random enable mix, including idle edges.
    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom); sel = 2'($urandom); y = 8'($urandom);
      @(posedge clk);
      model_edge(en, sel, y);
      #1;
      chk4($sformatf("rnd_en%0d", i), model[0], model[1], model[2], model[3]);
    end

    // 1-bit bus corner.
    en = 1'b0;
    en1 = 1'b1; sel1 = 2'd2; y1 = 1'b1;
    @(posedge clk); #1;
    chk("w1.a", {7'd0, a1}, 8'h00);
    chk("w1.b", {7'd0, b1}, 8'h00);
    chk("w1.c", {7'd0, c1}, 8'h01);
    chk("w1.d", {7'd0, d1}, 8'h00);
    en1 = 1'b1; sel1 = 2'd3; y1 = 1'b1;
    @(posedge clk); #1;
    chk("w1.c2", {7'd0, c1}, HOLD ? 8'h01 : 8'h00);
    chk("w1.d2", {7'd0, d1}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
